// File: rtl/i2c_target.sv
// Write-only I2C target receiver.
// Conditions the pad-level SCL/SDA lines, detects START/STOP, matches a 7-bit
// write address, ACKs the address and the first two data bytes, and presents
// the two data bytes with a one-cycle valid strobe when a STOP closes a
// complete two-byte transfer.
module i2c_target #(
  parameter logic [6:0] ADDR   = 7'h11,
  parameter int         FILTER = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            SCL,
  input  logic            SDA,
  output logic            SDA_oe,
  output logic [1:0][7:0] rdata,
  output logic            valid,
  output logic            busy
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_t;

  logic          scl_s1_r, scl_s2_r, sda_s1_r, sda_s2_r;
  logic          scl_f_r, sda_f_r, scl_p_r, sda_p_r;
  logic [CW-1:0] scl_cnt_r, sda_cnt_r;
  logic          scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t          state_r, state_n;
  logic [3:0]      bit_cnt_r, bit_cnt_n;
  logic [1:0]      byte_cnt_r, byte_cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic [1:0][7:0] hold_r, hold_n;
  logic [1:0][7:0] rdata_r, rdata_n;
  logic            sda_oe_r, sda_oe_n;
  logic            valid_r, valid_n;
  logic            busy_r, busy_n;

  // Two-flop synchronizers; idle bus level is high on both lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_r <= 1'b1;
      scl_s2_r <= 1'b1;
      sda_s1_r <= 1'b1;
      sda_s2_r <= 1'b1;
    end else begin
      scl_s1_r <= SCL;
      scl_s2_r <= scl_s1_r;
      sda_s1_r <= SDA;
      sda_s2_r <= sda_s1_r;
    end
  end

  // SCL stability filter: level follows only after FILTER differing samples in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f_r   <= 1'b1;
      scl_cnt_r <= '0;
    end else if (scl_s2_r == scl_f_r) begin
      scl_cnt_r <= '0;
    end else if (scl_cnt_r == CW'(FILTER - 1)) begin
      scl_f_r   <= scl_s2_r;
      scl_cnt_r <= '0;
    end else begin
      scl_cnt_r <= scl_cnt_r + CW'(1);
    end
  end

  // SDA stability filter, identical to the SCL one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_f_r   <= 1'b1;
      sda_cnt_r <= '0;
    end else if (sda_s2_r == sda_f_r) begin
      sda_cnt_r <= '0;
    end else if (sda_cnt_r == CW'(FILTER - 1)) begin
      sda_f_r   <= sda_s2_r;
      sda_cnt_r <= '0;
    end else begin
      sda_cnt_r <= sda_cnt_r + CW'(1);
    end
  end

  // Previous filtered levels for edge and bus-condition detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_p_r <= 1'b1;
      sda_p_r <= 1'b1;
    end else begin
      scl_p_r <= scl_f_r;
      sda_p_r <= sda_f_r;
    end
  end

  // SCL must be high in both samples so an SDA change coinciding with an SCL edge is not a START/STOP.
  assign scl_rise_s = scl_f_r & ~scl_p_r;
  assign scl_fall_s = ~scl_f_r & scl_p_r;
  assign start_s    = sda_p_r & ~sda_f_r & scl_f_r & scl_p_r;
  assign stop_s     = ~sda_p_r & sda_f_r & scl_f_r & scl_p_r;

  // Protocol FSM next-state and datapath: START/STOP override every state.
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    byte_cnt_n = byte_cnt_r;
    shift_n    = shift_r;
    hold_n     = hold_r;
    rdata_n    = rdata_r;
    sda_oe_n   = sda_oe_r;
    valid_n    = 1'b0;
    busy_n     = busy_r;
    if (start_s) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = 4'd0;
      byte_cnt_n = 2'd0;
      busy_n     = 1'b1;
      sda_oe_n   = 1'b0;
    end else if (stop_s) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      busy_n    = 1'b0;
      sda_oe_n  = 1'b0;
      if (byte_cnt_r == 2'd2) begin
        rdata_n = hold_r;
        valid_n = 1'b1;
      end else begin
        rdata_n = rdata_r;
      end
    end else begin
      case (state_r)
        ST_ADDR: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_n   = {shift_r[6:0], sda_f_r};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            if ((shift_r[7:1] == ADDR) && !shift_r[0]) begin
              sda_oe_n = 1'b1;
              state_n  = ST_ADDR_ACK;
            end else begin
              state_n = ST_IGNORE;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        ST_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_n   = {shift_r[6:0], sda_f_r};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            if (byte_cnt_r == 2'd0) begin
              hold_n[1]  = shift_r;
              byte_cnt_n = 2'd1;
              sda_oe_n   = 1'b1;
              state_n    = ST_DATA_ACK;
            end else if (byte_cnt_r == 2'd1) begin
              hold_n[0]  = shift_r;
              byte_cnt_n = 2'd2;
              sda_oe_n   = 1'b1;
              state_n    = ST_DATA_ACK;
            end else begin
              // Third byte: NACK it and poison the count so STOP gives no strobe.
              byte_cnt_n = 2'd3;
              state_n    = ST_IGNORE;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 4'd0;
            state_n   = ST_DATA;
          end else begin
            sda_oe_n = 1'b1;
          end
        end
        ST_IGNORE: begin
          sda_oe_n = 1'b0;
        end
        ST_IDLE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // FSM state and datapath registers; all outputs come straight from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      byte_cnt_r <= 2'd0;
      shift_r    <= 8'h00;
      hold_r     <= '0;
      rdata_r    <= '0;
      sda_oe_r   <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      byte_cnt_r <= byte_cnt_n;
      shift_r    <= shift_n;
      hold_r     <= hold_n;
      rdata_r    <= rdata_n;
      sda_oe_r   <= sda_oe_n;
      valid_r    <= valid_n;
      busy_r     <= busy_n;
    end
  end

  assign SDA_oe = sda_oe_r;
  assign rdata  = rdata_r;
  assign valid  = valid_r;
  assign busy   = busy_r;

endmodule
